// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes, frame
// length and the microsecond-to-cycle conversion used to size counters.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  localparam int unsigned FRAME_LEN = 11;

  // 64-bit product so TIMEOUT_US * CLK_FREQ_HZ cannot overflow.
  function automatic int unsigned us_to_cycles(input int unsigned us,
                                               input int unsigned hz);
    logic [63:0] prod;
    prod = 64'(us) * 64'(hz);
    return 32'(prod / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-FF synchronizer, level filter requiring
// FILTER_CYCLES consecutive equal samples, and a falling-edge pulse.
module ps2_line_sync #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, bit shifting on
// device clock falls, line-ack check and timeout, open-drain via output enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
  parameter int unsigned INHIBIT_US    = 100,
  parameter int unsigned TIMEOUT_US    = 15000,
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
  localparam int unsigned TIMEOUT_CYC = us_to_cycles(TIMEOUT_US, CLK_FREQ_HZ);
  localparam int unsigned MAX_CYC     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int unsigned CNT_W       = $clog2(MAX_CYC + 1);

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

  ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_sync (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .line_in(PS2_CLK_IN),
    .level(clk_lvl), .fall(clk_fall)
  );

  ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_sync (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .line_in(PS2_DATA_IN),
    .level(data_lvl), .fall(data_fall_unused)
  );

  ps2_tx_state_e state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic             ack_ok_q, ack_ok_d, done_q, done_d, err_q, err_d;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_ok_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_ok_q  <= ack_ok_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_ok_d  = ack_ok_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          ack_ok_d = 1'b0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        clk_oe_d = 1'b0;
        bit_d    = '0;
        cnt_d    = '0;
        state_d  = SEND;
      end
      SEND, ACK: begin
        // Timeout wins over a coincident fall so each frame yields one pulse.
        if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          ack_ok_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_fall) begin
            if (state_q == SEND) begin
              data_oe_d = ~frame_q[bit_q];
              bit_d     = bit_q + 4'd1;
              if (bit_q == 4'(FRAME_LEN - 2)) state_d = ACK;
            end else begin
              if (!data_lvl) ack_ok_d = 1'b1;
              else           err_d    = 1'b1;
              state_d = WAIT_IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          done_d  = ack_ok_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset), over the same PS2_CLK/PS2_DATA pair the receive path decodes. It drives both lines open-drain through output-enable signals, runs the inhibit/request-to-send sequence, shifts the frame on device-generated clock edges, and checks the device line-ack. It sits beside the keyboard receive path; the top level ties the output enables to tri-state pads.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency used to derive the cycle counts below.
- INHIBIT_US, 100, minimum time PS2_CLK is held low before the request-to-send.
- TIMEOUT_US, 15000, maximum time from clock release to the end of the ack bit.
- FILTER_CYCLES, 8, number of consecutive equal synchronized samples needed to accept a PS2_CLK level change.

Ports:
- CLK100MHZ  in  1  system clock.
- CPU_RESETN  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; a byte is accepted on tx_valid && tx_ready.
- busy  out  1  high whenever not in IDLE.
- tx_done  out  1  one-cycle pulse when a frame completes with the ack received.
- tx_err  out  1  one-cycle pulse on missing ack or timeout.
- PS2_CLK_IN  in  1  pad input of the clock line (asynchronous).
- PS2_DATA_IN  in  1  pad input of the data line (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release.
- ps2_data_oe  out  1  1 = drive PS2_DATA low, 0 = release.

Behaviour:
- Reset (async, CPU_RESETN=0): state IDLE, tx_ready=1, busy=0, both oe=0, tx_done=0, tx_err=0, shift register and counters cleared.
- Inputs pass through a 2-FF synchronizer and then the glitch filter. A falling edge (fall) is a filtered 1->0 transition of the clock line.
- IDLE: on tx_valid && tx_ready:
  - latch the frame {stop=1, parity=~^tx_data, tx_data} (odd parity);
  - go to INHIBIT on the next cycle.
- INHIBIT: ps2_clk_oe=1 for INHIBIT_US*CLK_FREQ_HZ/1e6 cycles (10000 at the defaults). Then go to REQ.
- REQ: ps2_data_oe=1 (start bit = 0) for 1 cycle with the clock still held, then ps2_clk_oe=0. Start the timeout counter and go to SEND with bit index 0.
- SEND: on each fall, present the next bit on data, with ps2_data_oe = ~bit:
  - falls 1..8 present data bits 0..7, LSB first;
  - fall 9 presents parity;
  - fall 10 releases data (stop bit).
  After fall 10, go to ACK.
- ACK: on the next fall (11th), sample filtered data.
  - Data 0: device ack; go to WAIT_IDLE.
  - Data 1: pulse tx_err and go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock and data are both 1.
  - Pulse tx_done, but only if the ack was good.
  - Return to IDLE.
- Timeout: the counter runs from clock release through ACK. Reaching TIMEOUT_US cycles in REQ/SEND/ACK does the following:
  - both oe=0;
  - tx_err pulses;
  - the block enters WAIT_IDLE and no tx_done follows.
- tx_done and tx_err are never asserted in the same cycle. Each frame produces exactly one of them.
- tx_valid while busy is ignored; no queuing, and tx_data is not re-sampled.
- Reset mid-frame releases both lines immediately (asynchronously). No pulse is emitted.
- A fall arriving in IDLE or INHIBIT is ignored.
- Counters are wide enough for TIMEOUT_US at CLK_FREQ_HZ (21 bits at the defaults); the derived constant is computed with integer arithmetic.

Decomposition:
- Package ps2_pkg holds:
  - state enum {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE};
  - command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RESP_ACK=8'hFA;
  - frame length constant 11.
- Sub-module ps2_line_sync: 2-FF synchronizer, FILTER_CYCLES filter and falling-edge pulse. It is instantiated once for the clock and once for the data line, and is reusable by the receive path.

Test Plan:
- Send 0xED with a device model that acks: the data line carries 1,0,1,1,0,1,1,1, then parity 1, stop 1; ack sampled low; tx_done pulses once; tx_err stays 0.
- Send 0xF4: parity bit = 0 (five ones); ps2_clk_oe stays high for exactly 10000 cycles before data goes low.
- Device model never clocks after release: tx_err pulses at 1,500,000 cycles after release; both oe=0; no tx_done; tx_ready returns once the lines are high.
- Device leaves data high on the 11th fall (no ack): tx_err pulses; the block returns to IDLE.
- Assert CPU_RESETN=0 during bit 4: both oe drop to 0 in the same cycle; tx_ready=1 after release; no pulses.
- Pulse tx_valid with 0xFF during SEND of 0xED: it is ignored; the frame bits are unchanged; only one tx_done is seen.
- A 3-cycle low glitch on PS2_CLK_IN during SEND is not counted as a fall; the bit index is unchanged.
